red_bbox_tracker: RTL

Per-frame bounding-box tracker that consumes the per-pixel `red_sector` classification produced by the vision processing pipeline. It sits downstream of the pixel classifier and accumulates min/max pixel coordinates and a hit count of red pixels across each frame. At end of frame it publishes the box on parallel outputs. It also serialises the box as three 32-bit words over a valid/ready message interface to the rover control processor.

---
 rtl/vision_pkg.sv | 23 ++
 rtl/bbox_msg_tx.sv | 65 ++++++
 rtl/red_bbox_tracker.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vision_pkg.sv
// Shared definitions for the vision pipeline: image geometry defaults,
// the bounding-box record and the message word tags.
package vision_pkg;

    localparam int COORD_W     = 11;
    localparam int COUNT_W     = 20;
    localparam int DEF_IMAGE_W = 640;
    localparam int DEF_IMAGE_H = 480;

    localparam logic [1:0] MSG_TAG_X   = 2'b01;
    localparam logic [1:0] MSG_TAG_Y   = 2'b10;
    localparam logic [1:0] MSG_TAG_CNT = 2'b11;

    typedef struct packed {
        logic [COORD_W-1:0] left;
        logic [COORD_W-1:0] right;
        logic [COORD_W-1:0] top;
        logic [COORD_W-1:0] bottom;
        logic [COUNT_W-1:0] count;
        logic               found;
    } bbox_t;

endpackage

// File: rtl/bbox_msg_tx.sv
// Three-word valid/ready serialiser for one bounding-box record.
//
// state   | meaning
// --------+------------------------------------------------------
// ST_IDLE | no record pending; a load strobe captures a snapshot
// ST_W0   | presenting {tag X, left, right}
// ST_W1   | presenting {tag Y, top, bottom}
// ST_W2   | presenting {tag CNT, found, count}
module bbox_msg_tx
    import vision_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  bbox_t       box_in,
    output logic        busy,
    output logic        msg_valid,
    input  logic        msg_ready,
    output logic [31:0] msg_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_W0   = 2'd1;
    localparam logic [1:0] ST_W1   = 2'd2;
    localparam logic [1:0] ST_W2   = 2'd3;

    logic [1:0] state;
    bbox_t      snap;

    // Snapshot capture and word sequencing; a word advances only on handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            snap  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        state <= ST_W0;
                        snap  <= box_in;
                    end
                end
                ST_W0:   if (msg_ready) state <= ST_W1;
                ST_W1:   if (msg_ready) state <= ST_W2;
                ST_W2:   if (msg_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign msg_valid = busy;

    // Word formatting from the held snapshot; stays stable while stalled.
    always_comb begin
        msg_data = '0;
        case (state)
            ST_W0:   msg_data = {MSG_TAG_X, 3'b000, snap.left, 5'b00000, snap.right};
            ST_W1:   msg_data = {MSG_TAG_Y, 3'b000, snap.top, 5'b00000, snap.bottom};
            ST_W2:   msg_data = {MSG_TAG_CNT, snap.found, 9'b0, snap.count};
            default: msg_data = '0;
        endcase
    end

endmodule

// File: rtl/red_bbox_tracker.sv
// Per-frame red-pixel bounding-box tracker. Accumulates min/max coordinates
// and a hit count between sop and the last pixel of the frame, publishes the
// result on parallel outputs and hands a snapshot to the message serialiser.
module red_bbox_tracker
    import vision_pkg::*;
#(
    parameter int IMAGE_W    = DEF_IMAGE_W,
    parameter int IMAGE_H    = DEF_IMAGE_H,
    parameter int MIN_PIXELS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               sop,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               red_sector,
    output logic               frame_done,
    output logic               box_found,
    output logic [COORD_W-1:0] box_left,
    output logic [COORD_W-1:0] box_right,
    output logic [COORD_W-1:0] box_top,
    output logic [COORD_W-1:0] box_bottom,
    output logic [COUNT_W-1:0] box_count,
    output logic               msg_valid,
    input  logic               msg_ready,
    output logic [31:0]        msg_data,
    output logic               overrun
);

    localparam logic [COORD_W-1:0] LAST_X  = COORD_W'(IMAGE_W - 1);
    localparam logic [COORD_W-1:0] LAST_Y  = COORD_W'(IMAGE_H - 1);
    localparam logic [COUNT_W-1:0] MIN_CNT = COUNT_W'(MIN_PIXELS);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic [COORD_W-1:0] acc_l, acc_r, acc_t, acc_b;
    logic [COUNT_W-1:0] acc_cnt;
    logic               armed;

    logic [COORD_W-1:0] base_l, base_r, base_t, base_b;
    logic [COUNT_W-1:0] base_cnt;
    logic [COORD_W-1:0] nxt_l, nxt_r, nxt_t, nxt_b;
    logic [COUNT_W-1:0] nxt_cnt;
    logic               live, hit, frame_end;
    bbox_t              res_box;
    logic               tx_busy;

    // Next accumulator values: sop reloads first, then the pixel is applied.
    always_comb begin
        base_l   = acc_l;
        base_r   = acc_r;
        base_t   = acc_t;
        base_b   = acc_b;
        base_cnt = acc_cnt;
        if (sop) begin
            base_l   = '1;
            base_t   = '1;
            base_r   = '0;
            base_b   = '0;
            base_cnt = '0;
        end
        live      = in_valid && (armed || sop);
        hit       = live && red_sector;
        frame_end = live && (x == LAST_X) && (y == LAST_Y);
        nxt_l     = base_l;
        nxt_r     = base_r;
        nxt_t     = base_t;
        nxt_b     = base_b;
        nxt_cnt   = base_cnt;
        if (hit) begin
            nxt_l   = (x < base_l) ? x : base_l;
            nxt_r   = (x > base_r) ? x : base_r;
            nxt_t   = (y < base_t) ? y : base_t;
            nxt_b   = (y > base_b) ? y : base_b;
            nxt_cnt = (base_cnt == CNT_MAX) ? base_cnt : base_cnt + 1'b1;
        end
    end

    // Frame result including the current (final) pixel; coordinates zeroed when not found.
    always_comb begin
        res_box       = '0;
        res_box.found = (nxt_cnt >= MIN_CNT);
        res_box.count = nxt_cnt;
        if (res_box.found) begin
            res_box.left   = nxt_l;
            res_box.right  = nxt_r;
            res_box.top    = nxt_t;
            res_box.bottom = nxt_b;
        end
    end

    // Accumulators and frame arming; only accepted pixels of an armed frame touch them.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_l   <= '1;
            acc_t   <= '1;
            acc_r   <= '0;
            acc_b   <= '0;
            acc_cnt <= '0;
            armed   <= 1'b0;
        end else if (live) begin
            acc_l   <= nxt_l;
            acc_r   <= nxt_r;
            acc_t   <= nxt_t;
            acc_b   <= nxt_b;
            acc_cnt <= nxt_cnt;
            armed   <= !frame_end;
        end
    end

    // Published result and end-of-frame pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            box_found  <= 1'b0;
            box_left   <= '0;
            box_right  <= '0;
            box_top    <= '0;
            box_bottom <= '0;
            box_count  <= '0;
        end else begin
            frame_done <= frame_end;
            overrun    <= frame_end && tx_busy;
            if (frame_end) begin
                box_found  <= res_box.found;
                box_left   <= res_box.left;
                box_right  <= res_box.right;
                box_top    <= res_box.top;
                box_bottom <= res_box.bottom;
                box_count  <= res_box.count;
            end
        end
    end

    bbox_msg_tx u_msg_tx (
        .clk       (clk),
        .reset     (reset),
        .load      (frame_end && !tx_busy),
        .box_in    (res_box),
        .busy      (tx_busy),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_data  (msg_data)
    );

endmodule
